// File: rtl/prio_encoder_rr.sv
// Registered N-way priority encoder: LSB-first, MSB-first or round-robin per sample.
// One-cycle latency; a held result blocks capture until out_ready, so in_ready = !out_valid || out_ready.
module prio_encoder_rr #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [1:0]   mode,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] idx,
  output logic [N-1:0] grant,
  output logic         found
);

  logic         r_out_valid;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_grant;
  logic         r_found;
  logic [W-1:0] r_ptr;

  logic         w_cap;
  logic         w_found;
  logic         w_hit;
  logic [W-1:0] w_idx;
  logic [N-1:0] w_grant;
  logic [W-1:0] w_ptr_nxt;
  int           w_k;

  assign in_ready = !r_out_valid || out_ready;
  assign w_cap    = in_valid && in_ready;

  always_comb begin
    w_found = |req;
    w_hit   = 1'b0;
    w_idx   = '0;
    w_k     = 0;
    case (mode)
      2'b01: begin
        for (int i = 0; i < N; i++)
          if (req[i]) w_idx = W'(i);
      end
      2'b10: begin
        // Scan starts at the pointer and wraps at N-1, not at 2**W.
        for (int i = 0; i < N; i++) begin
          w_k = int'(r_ptr) + i;
          if (w_k >= N) w_k = w_k - N;
          if (!w_hit && req[w_k]) begin
            w_hit = 1'b1;
            w_idx = W'(w_k);
          end
        end
      end
      default: begin
        for (int i = N - 1; i >= 0; i--)
          if (req[i]) w_idx = W'(i);
      end
    endcase
  end

  assign w_grant   = w_found ? ({{(N-1){1'b0}}, 1'b1} << w_idx) : '0;
  assign w_ptr_nxt = (w_idx == W'(N - 1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_idx       <= '0;
      r_grant     <= '0;
      r_found     <= 1'b0;
      r_ptr       <= '0;
    end else if (w_cap) begin
      r_out_valid <= 1'b1;
      r_idx       <= w_idx;
      r_grant     <= w_grant;
      r_found     <= w_found;
      if (mode == 2'b10 && w_found) r_ptr <= w_ptr_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign idx       = r_idx;
  assign grant     = r_grant;
  assign found     = r_found;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr at N=8 and at non-power-of-two N=5.
module tb_prio_encoder_rr;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_ready, out_valid, out_ready, found;
  logic [7:0] req, grant;
  logic [1:0] mode;
  logic [2:0] idx;

  logic       rst5, in_valid5, in_ready5, out_valid5, out_ready5, found5;
  logic [4:0] req5, grant5;
  logic [1:0] mode5;
  logic [2:0] idx5;

  int n_vec = 0;
  int n_err = 0;

  prio_encoder_rr #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .req(req), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .idx(idx), .grant(grant), .found(found)
  );

  prio_encoder_rr #(.N(5)) dut5 (
    .clk(clk), .rst(rst5), .req(req5), .mode(mode5), .in_valid(in_valid5),
    .in_ready(in_ready5), .out_valid(out_valid5), .out_ready(out_ready5),
    .idx(idx5), .grant(grant5), .found(found5)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] i,
                         input logic [7:0] g, input logic f);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".idx"},       64'(idx),       64'(i));
    chk({tag, ".grant"},     64'(grant),     64'(g));
    chk({tag, ".found"},     64'(found),     64'(f));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; req = '0; mode = 2'b00;
    rst5 = 1'b1; in_valid5 = 1'b0; out_ready5 = 1'b1; req5 = '0; mode5 = 2'b00;
    tick(); tick();
    rst = 1'b0;
    chk_out("reset", 1'b0, 3'd0, 8'h00, 1'b0);
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    chk("reset.ptr", 64'(dut8.r_ptr), 64'd0);

    // Fixed-priority modes
    mode = 2'b00; req = 8'b1010_1000; in_valid = 1'b1;
    tick();
    chk_out("lsb", 1'b1, 3'd3, 8'h08, 1'b1);
    mode = 2'b01;
    tick();
    chk_out("msb", 1'b1, 3'd7, 8'h80, 1'b1);
    mode = 2'b11;
    tick();
    chk_out("mode11", 1'b1, 3'd3, 8'h08, 1'b1);
    chk("fixed.ptr", 64'(dut8.r_ptr), 64'd0);
    in_valid = 1'b0;
    tick();
    chk("drain.out_valid", 64'(out_valid), 64'd0);

    // Round-robin from reset
    rst = 1'b1; tick(); rst = 1'b0;
    mode = 2'b10; req = 8'b1000_1001; in_valid = 1'b1;
    tick(); chk("rr0.idx", 64'(idx), 64'd0); chk("rr0.ptr", 64'(dut8.r_ptr), 64'd1);
    tick(); chk("rr1.idx", 64'(idx), 64'd3); chk("rr1.ptr", 64'(dut8.r_ptr), 64'd4);
    tick(); chk("rr2.idx", 64'(idx), 64'd7); chk("rr2.ptr", 64'(dut8.r_ptr), 64'd0);
    tick(); chk("rr3.idx", 64'(idx), 64'd0); chk("rr3.ptr", 64'(dut8.r_ptr), 64'd1);

    // Backpressure hold then same-edge capture
    mode = 2'b00; req = 8'h10;
    tick();
    chk_out("bp.cap", 1'b1, 3'd4, 8'h10, 1'b1);
    out_ready = 1'b0; req = 8'h02; #1;
    chk("bp.in_ready0", 64'(in_ready), 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_out("bp.hold", 1'b1, 3'd4, 8'h10, 1'b1);
      chk("bp.in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1; #1;
    chk("bp.in_ready1", 64'(in_ready), 64'd1);
    tick();
    chk_out("bp.next", 1'b1, 3'd1, 8'h02, 1'b1);
    chk("bp.ptr", 64'(dut8.r_ptr), 64'd1);

    // Empty request with ptr at 5
    mode = 2'b10; req = 8'h10;
    tick(); chk("emp.setup.ptr", 64'(dut8.r_ptr), 64'd5);
    req = 8'h00;
    tick();
    chk_out("empty", 1'b1, 3'd0, 8'h00, 1'b0);
    chk("empty.ptr", 64'(dut8.r_ptr), 64'd5);

    // Reset during a stall
    req = 8'h20;
    tick(); chk("rst.setup.idx", 64'(idx), 64'd5); chk("rst.setup.ptr", 64'(dut8.r_ptr), 64'd6);
    in_valid = 1'b0; out_ready = 1'b0;
    tick(); chk("rst.stall.out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_out("rst.stall", 1'b0, 3'd0, 8'h00, 1'b0);
    chk("rst.stall.ptr", 64'(dut8.r_ptr), 64'd0);
    chk("rst.stall.in_ready", 64'(in_ready), 64'd1);
    mode = 2'b10; req = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk_out("rst.after", 1'b1, 3'd0, 8'h01, 1'b1);

    // in_valid low leaves state alone
    in_valid = 1'b0; out_ready = 1'b0; req = 8'h80; mode = 2'b01;
    tick();
    chk_out("idle.hold", 1'b1, 3'd0, 8'h01, 1'b1);
    chk("idle.ptr", 64'(dut8.r_ptr), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("idle.drain", 64'(out_valid), 64'd0);

    // N=5 round-robin wrap at 4
    rst5 = 1'b0;
    mode5 = 2'b10; req5 = 5'b10001; in_valid5 = 1'b1;
    tick(); chk("n5.0.idx", 64'(idx5), 64'd0); chk("n5.0.grant", 64'(grant5), 64'h01);
    tick(); chk("n5.1.idx", 64'(idx5), 64'd4); chk("n5.1.grant", 64'(grant5), 64'h10);
    chk("n5.1.ptr", 64'(dut5.r_ptr), 64'd0);
    tick(); chk("n5.2.idx", 64'(idx5), 64'd0); chk("n5.2.ptr", 64'(dut5.r_ptr), 64'd1);
    mode5 = 2'b01; req5 = 5'b00110;
    tick(); chk("n5.msb.idx", 64'(idx5), 64'd2); chk("n5.msb.found", 64'(found5), 64'd1);
    in_valid5 = 1'b0;
    tick(); chk("n5.drain", 64'(out_valid5), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised, registered priority encoder. Successor to the 4-bit combinational LSB/MSB encoder.
- Generalised to N request lines, with run-time mode select: fixed LSB-first, fixed MSB-first, or round-robin (rotating pointer).
- Adds a found flag, a one-hot grant and a valid/ready output handshake with backpressure.
- Sits between request sources (interrupt lines, channel requests) and a downstream consumer that may stall.

Parameters:
- N, 8, number of request lines; legal range 2..64, need not be a power of two.
- W, $clog2(N), width of the encoded index output; derived, not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  N  request vector; bit k = request from source k.
- mode  in  2  00 = LSB-first, 01 = MSB-first, 10 = round-robin, 11 = reserved (behaves as 00).
- in_valid  in  1  req/mode are to be sampled this cycle.
- in_ready  out  1  block can accept a sample this cycle.
- out_valid  out  1  registered result present.
- out_ready  in  1  downstream accepts the result this cycle.
- idx  out  W  encoded index of the winning request.
- grant  out  N  one-hot of the winner; all zero when found=0.
- found  out  1  1 = at least one request bit was set in the sampled req.

Behaviour:
- Reset (rst=1 at a clk edge) overrides everything: out_valid=0, idx=0, grant=0, found=0, rr pointer ptr=0.
  - A held but unaccepted result is discarded.
  - in_ready is 1 in the cycle after reset.
- in_ready = !out_valid || out_ready (combinational; no dependency on in_valid).
- Capture: occurs at an edge with in_valid && in_ready.
  - req and mode are evaluated combinationally and registered.
  - out_valid=1 on the next cycle: latency 1 cycle from capture to result.
- Throughput: one result per cycle while out_ready=1.
  - Capture and accept in the same cycle is legal; the new result replaces the old one.
- Hold: if out_valid=1 and out_ready=0, then idx/grant/found/out_valid are held stable and no capture occurs.
- Drain: out_valid falls to 0 after an edge with out_ready=1 and no capture.
- LSB-first: winner = lowest k with req[k]=1.
- MSB-first: winner = highest k with req[k]=1.
- Round-robin:
  - Winner = first k with req[k]=1 scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - The scan wraps at N-1, also when N is not a power of two.
- Pointer update on capture, only in mode 10 with found=1: ptr <= (winner==N-1) ? 0 : winner+1.
  - Mode 00/01/11 captures and found=0 captures leave ptr unchanged.
  - ptr persists across mode changes.
- Empty req (all zero) on capture: found=0, idx=0, grant=0, out_valid=1. The empty result is still handshaked.
- idx is zero-extended to W bits; grant == (1 << idx) whenever found=1.
- Inputs are ignored when in_valid=0; no state changes.

Test Plan:
- N=8, mode=00, req=8'b1010_1000, in_valid=1 -> next cycle out_valid=1, idx=3, grant=8'h08, found=1.
- Same req with mode=01 -> idx=7, grant=8'h80. With mode=11 -> idx=3.
- Round-robin: mode=10, req=8'b1000_1001 held, out_ready=1, 4 back-to-back captures after reset -> idx sequence 0, 3, 7, 0; ptr after these captures = 1, 4, 0, 1.
- Backpressure: capture req=8'h10, then out_ready=0 for 3 cycles while in_valid=1 with req=8'h02.
  - Required: idx=4 held, in_ready=0 throughout.
  - When out_ready=1 -> same-edge capture; next cycle idx=1.
- Empty: req=0, mode=10, ptr=5 -> found=0, idx=0, grant=0, out_valid=1, ptr stays 5.
- Reset mid-stall: out_valid=1, out_ready=0, ptr=6, assert rst one cycle -> out_valid=0, idx=0, grant=0, ptr=0. A following mode=10 capture with req=8'hFF -> idx=0.
- Non-power-of-two: N=5, mode=10, req=5'b10001 -> idx 0, 4, 0 (wrap at 4).
